// File: rtl/posi_mem_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | posi_mem_arb_if : write/read request bus of the posi_mem_arb block  |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
interface posi_mem_arb_if #(
   parameter int DAT_W = 32,
   parameter int ADR_W = 8
);
   logic             wr_ena_i;
   logic [ADR_W-1:0] wr_adr_i;
   logic [DAT_W-1:0] wr_dat_i;
   logic             wr_rdy_o;
   logic             rd_ena_i;
   logic [ADR_W-1:0] rd_adr_i;
   logic [DAT_W-1:0] rd_dat_o;
   logic             rd_val_o;
   logic             pnd_o;

   modport master (
      output wr_ena_i, wr_adr_i, wr_dat_i, rd_ena_i, rd_adr_i,
      input  wr_rdy_o, rd_dat_o, rd_val_o, pnd_o
   );

   modport slave (
      input  wr_ena_i, wr_adr_i, wr_dat_i, rd_ena_i, rd_adr_i,
      output wr_rdy_o, rd_dat_o, rd_val_o, pnd_o
   );
endinterface
`default_nettype wire

// File: rtl/posi_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | posi_mem_arb : single-port memory, reads win, writes park in a     |
// |                one-entry pending buffer with read bypass           |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module posi_mem_arb #(
   parameter int DAT_W = 32,
   parameter int DEPTH = 256,
   parameter int ADR_W = 8
) (
   input wire            clk,
   input wire            rst,
   posi_mem_arb_if.slave bus
);

   // One extra bit so DEPTH == 2**ADR_W is representable.
   localparam logic [ADR_W:0] c_DEPTH_LIM = (ADR_W+1)'(DEPTH);

   logic [DAT_W-1:0] mem_q [DEPTH];

   logic             pnd_vld_q, pnd_vld_d;
   logic [ADR_W-1:0] pnd_adr_q, pnd_adr_d;
   logic [DAT_W-1:0] pnd_dat_q, pnd_dat_d;
   logic [DAT_W-1:0] rd_dat_q,  rd_dat_d;
   logic             rd_val_q,  rd_val_d;

   logic             wr_acc;
   logic             wr_in_rng;
   logic             rd_in_rng;
   logic             rd_hit_pnd;
   logic             mem_we;
   logic [ADR_W-1:0] mem_wadr;
   logic [DAT_W-1:0] mem_wdat;

   assign wr_in_rng  = {1'b0, bus.wr_adr_i} < c_DEPTH_LIM;
   assign rd_in_rng  = {1'b0, bus.rd_adr_i} < c_DEPTH_LIM;
   assign wr_acc     = bus.wr_ena_i && !pnd_vld_q;
   assign rd_hit_pnd = pnd_vld_q && (bus.rd_adr_i == pnd_adr_q);

   always_comb begin
      pnd_vld_d = pnd_vld_q;
      pnd_adr_d = pnd_adr_q;
      pnd_dat_d = pnd_dat_q;
      rd_val_d  = bus.rd_ena_i;
      rd_dat_d  = rd_dat_q;
      mem_we    = 1'b0;
      mem_wadr  = pnd_adr_q;
      mem_wdat  = pnd_dat_q;

      if (bus.rd_ena_i) begin
         // The read owns the array port; a same-cycle write is parked.
         if (rd_hit_pnd) begin
            rd_dat_d = pnd_dat_q;
         end else if (rd_in_rng) begin
            rd_dat_d = mem_q[bus.rd_adr_i];
         end else begin
            rd_dat_d = '0;
         end
         if (wr_acc && wr_in_rng) begin
            pnd_vld_d = 1'b1;
            pnd_adr_d = bus.wr_adr_i;
            pnd_dat_d = bus.wr_dat_i;
         end
      end else if (pnd_vld_q) begin
         mem_we    = 1'b1;
         pnd_vld_d = 1'b0;
      end else if (wr_acc && wr_in_rng) begin
         mem_we   = 1'b1;
         mem_wadr = bus.wr_adr_i;
         mem_wdat = bus.wr_dat_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pnd_vld_q <= 1'b0;
         pnd_adr_q <= '0;
         pnd_dat_q <= '0;
         rd_dat_q  <= '0;
         rd_val_q  <= 1'b0;
      end else begin
         pnd_vld_q <= pnd_vld_d;
         pnd_adr_q <= pnd_adr_d;
         pnd_dat_q <= pnd_dat_d;
         rd_dat_q  <= rd_dat_d;
         rd_val_q  <= rd_val_d;
      end
   end

   // Array contents survive reset; only writes are blocked while it is held.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[mem_wadr] <= mem_wdat;
      end
   end

   assign bus.wr_rdy_o = !pnd_vld_q;
   assign bus.pnd_o    = pnd_vld_q;
   assign bus.rd_dat_o = rd_dat_q;
   assign bus.rd_val_o = rd_val_q;

endmodule
`default_nettype wire

// File: tb/tb_posi_mem_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_posi_mem_arb : directed and random checks of posi_mem_arb       |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_posi_mem_arb;

   localparam int DAT_W = 32;
   localparam int ADR_W = 8;
   localparam int DEPTH = 240;

   logic clk = 1'b0;
   logic rst = 1'b1;

   posi_mem_arb_if #(.DAT_W(DAT_W), .ADR_W(ADR_W)) bus ();

   posi_mem_arb #(.DAT_W(DAT_W), .DEPTH(DEPTH), .ADR_W(ADR_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: committed memory plus the single parked write.
   logic [DAT_W-1:0] ref_mem [256];
   logic             m_pend = 1'b0;
   logic [ADR_W-1:0] m_padr = '0;
   logic [DAT_W-1:0] m_pdat = '0;
   logic [DAT_W-1:0] last_rd = '0;

   task automatic chk(input string tag, input logic [DAT_W-1:0] got, input logic [DAT_W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Called at posedge+1 (or later before negedge); returns at next posedge+1.
   task automatic do_cycle(input logic rd, input logic [ADR_W-1:0] ra,
                           input logic wr, input logic [ADR_W-1:0] wa,
                           input logic [DAT_W-1:0] wd);
      logic             acc;
      logic [DAT_W-1:0] exp_rd;
      bus.rd_ena_i = rd;
      bus.rd_adr_i = ra;
      bus.wr_ena_i = wr;
      bus.wr_adr_i = wa;
      bus.wr_dat_i = wd;
      #1;
      chk("wr_rdy", {31'b0, bus.wr_rdy_o}, {31'b0, !m_pend});
      chk("pnd",    {31'b0, bus.pnd_o},    {31'b0, m_pend});
      acc    = wr && !m_pend;
      exp_rd = '0;
      if (int'(ra) < DEPTH)
         exp_rd = (m_pend && m_padr == ra) ? m_pdat : ref_mem[ra];
      @(posedge clk);
      #1;
      if (m_pend && !rd) begin
         ref_mem[m_padr] = m_pdat;
         m_pend = 1'b0;
      end else if (acc && int'(wa) < DEPTH) begin
         if (rd) begin
            m_pend = 1'b1;
            m_padr = wa;
            m_pdat = wd;
         end else begin
            ref_mem[wa] = wd;
         end
      end
      if (rd) last_rd = exp_rd;
      chk("rd_val", {31'b0, bus.rd_val_o}, {31'b0, rd});
      chk("rd_dat", bus.rd_dat_o, last_rd);
   endtask

   initial begin
      logic [ADR_W-1:0] a;
      logic [ADR_W-1:0] b;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      bus.rd_ena_i = 1'b0;
      bus.rd_adr_i = '0;
      bus.wr_ena_i = 1'b0;
      bus.wr_adr_i = '0;
      bus.wr_dat_i = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_rdy", {31'b0, bus.wr_rdy_o}, 32'd1);
      chk("rst_pnd",    {31'b0, bus.pnd_o},    32'd0);
      chk("rst_rd_val", {31'b0, bus.rd_val_o}, 32'd0);
      chk("rst_rd_dat", bus.rd_dat_o,          32'd0);
      rst = 1'b0;

      // Give every in-range word a known value.
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, '0, 1'b1, ADR_W'(i), $urandom);

      // Direct write then read back.
      do_cycle(1'b0, '0, 1'b1, 8'd5, 32'hA5A5_A5A5);
      do_cycle(1'b1, 8'd5, 1'b0, '0, '0);
      chk("dir_rd5", bus.rd_dat_o, 32'hA5A5_A5A5);

      // Same-cycle read/write: old data out, write parked, then bypass.
      do_cycle(1'b0, '0, 1'b1, 8'd7, 32'h22);
      do_cycle(1'b1, 8'd7, 1'b1, 8'd7, 32'h11);
      chk("rbw_rd7", bus.rd_dat_o, 32'h22);
      chk("rbw_pnd", {31'b0, bus.pnd_o}, 32'd1);
      do_cycle(1'b1, 8'd7, 1'b0, '0, '0);
      chk("byp_rd7", bus.rd_dat_o, 32'h11);
      do_cycle(1'b0, '0, 1'b0, '0, '0);

      // Full buffer under four back-to-back reads; competing writes refused.
      do_cycle(1'b1, 8'd9, 1'b1, 8'd9, 32'hCAFE_0009);
      for (int i = 0; i < 4; i++) begin
         do_cycle(1'b1, (i % 2 == 0) ? 8'd9 : 8'd3, 1'b1, 8'd9, 32'hBAD0_0000 + i);
         chk("hold_rdy", {31'b0, bus.wr_rdy_o}, 32'd0);
      end
      do_cycle(1'b0, '0, 1'b1, 8'd9, 32'hBAD0_00FF);
      chk("drain_rdy", {31'b0, bus.wr_rdy_o}, 32'd1);
      do_cycle(1'b1, 8'd9, 1'b0, '0, '0);
      chk("drain_rd9", bus.rd_dat_o, 32'hCAFE_0009);

      // Out-of-range address and the last valid word.
      do_cycle(1'b0, '0, 1'b1, 8'd245, 32'hFF);
      do_cycle(1'b1, 8'd245, 1'b1, 8'd245, 32'hFF);
      chk("oor_rd", bus.rd_dat_o, 32'd0);
      chk("oor_pnd", {31'b0, bus.pnd_o}, 32'd0);
      do_cycle(1'b0, '0, 1'b1, 8'd239, 32'h2390_0239);
      do_cycle(1'b1, 8'd239, 1'b0, '0, '0);
      chk("last_rd", bus.rd_dat_o, 32'h2390_0239);

      // Reset mid-cycle with a write parked: it must be dropped.
      do_cycle(1'b1, 8'd20, 1'b1, 8'd20, 32'hDEAD_BEEF);
      bus.rd_ena_i = 1'b0;
      bus.wr_ena_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("mrst_pnd",    {31'b0, bus.pnd_o},    32'd0);
      chk("mrst_wr_rdy", {31'b0, bus.wr_rdy_o}, 32'd1);
      chk("mrst_rd_val", {31'b0, bus.rd_val_o}, 32'd0);
      chk("mrst_rd_dat", bus.rd_dat_o,          32'd0);
      #1;
      rst     = 1'b0;
      m_pend  = 1'b0;
      last_rd = '0;
      do_cycle(1'b1, 8'd20, 1'b0, '0, '0);

      // Random traffic concentrated near the range edge to provoke bypass hits.
      for (int i = 0; i < 2000; i++) begin
         a = ($urandom % 4 == 0) ? ADR_W'($urandom % 256) : ADR_W'(230 + $urandom % 16);
         b = ($urandom % 4 == 0) ? ADR_W'($urandom % 256) : ADR_W'(230 + $urandom % 16);
         do_cycle(1'($urandom), a, 1'($urandom), b, $urandom);
      end

      // Flush and read back every word to catch lost writes.
      do_cycle(1'b0, '0, 1'b0, '0, '0);
      for (int i = 0; i < 256; i++) do_cycle(1'b1, ADR_W'(i), 1'b0, '0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/posi_mem_arb.md
POSI_MEM_ARB -- requirements
Module: posi_mem_arb

Interface
REQ-001 Parameter DAT_W, default 32, shall set the data word width in bits.
REQ-002 Parameter DEPTH, default 256, shall set the number of words (any value 2..2^ADR_W, e.g. 240).
REQ-003 Parameter ADR_W, default 8, shall set the address width.
REQ-004 clk  input  1  shall be the single clock; all state shall change on its rising edge.
REQ-005 rst  input  1  shall be the reset, asynchronous and active-high.
REQ-006 wr_ena_i  input  1  shall be the write request.
REQ-007 wr_adr_i  input  ADR_W  shall be the write address.
REQ-008 wr_dat_i  input  DAT_W  shall be the write data.
REQ-009 wr_rdy_o  output  1  shall be the write-ready flag; a write is accepted when wr_ena_i && wr_rdy_o.
REQ-010 rd_ena_i  input  1  shall be the read request, always accepted.
REQ-011 rd_adr_i  input  ADR_W  shall be the read address.
REQ-012 rd_dat_o  output  DAT_W  shall be the registered read data.
REQ-013 rd_val_o  output  1  shall flag that rd_dat_o holds data for the read issued in the previous cycle.
REQ-014 pnd_o  output  1  shall flag that the pending-write buffer is occupied.

Function
REQ-015 The block shall contain a DEPTH x DAT_W single-port array with at most one array access (read or write) per cycle.
REQ-016 The block shall contain a one-entry pending-write buffer (pnd_vld, pnd_adr, pnd_dat); pnd_o shall equal pnd_vld.
REQ-017 wr_rdy_o shall equal !pnd_vld (registered state only, no combinational path from inputs).
REQ-018 Array port priority per cycle shall be: read > pending drain > accepted incoming write.
REQ-019 Case no read, buffer empty, write accepted: the write shall go directly to the array.
REQ-020 Case no read, buffer full: the buffer shall drain to the array and pnd_vld shall clear at the next edge.
REQ-021 Case read, buffer empty, write accepted: the array shall serve the read and the write shall be captured into the buffer (pnd_vld=1 next cycle).
REQ-022 Case read, buffer full: the array shall serve the read and the buffer shall hold unchanged.
REQ-023 A read shall return the array content as of the start of the cycle (read-before-write); a write accepted in the same cycle to the same address shall not be visible to that read.
REQ-024 Bypass: when pnd_vld=1 at the start of the cycle and rd_adr_i==pnd_adr, rd_dat_o shall return pnd_dat instead of array data.
REQ-025 Read latency shall be exactly 1 cycle: rd_val_o=1 in the cycle after rd_ena_i=1, otherwise 0.
REQ-026 rd_dat_o shall hold its last value when no read is issued.
REQ-027 Writes with address >= DEPTH shall be accepted per the handshake rules and discarded, never entering the buffer or the array.
REQ-028 Reads with address >= DEPTH shall return all-zero data with rd_val_o asserted normally.
REQ-029 Under continuous reads with pnd_vld=1, wr_rdy_o shall stay 0 until the first read-free cycle; no write shall be lost or reordered.
REQ-030 A later write to pnd_adr shall not be accepted while the buffer is full, preserving write order.

Reset
REQ-031 While rst=1: pnd_vld=0, wr_rdy_o=1, pnd_o=0, rd_val_o=0, rd_dat_o=0.
REQ-032 Array contents shall not be reset; a pending write held when rst asserts shall be dropped.
REQ-033 The first accepted operation shall be at the first rising edge with rst=0.

Verification
REQ-034 Write adr 5 data 0xA5A5A5A5 with no read, then read adr 5 -> rd_val_o=1 one cycle later, rd_dat_o=0xA5A5A5A5.
REQ-035 Same cycle: write adr 7 data 0x11 and read adr 7 (array holds 0x22) -> rd_dat_o=0x22, pnd_o=1, wr_rdy_o=0; next cycle read adr 7 -> 0x11 via bypass.
REQ-036 Buffer full plus reads on 4 consecutive cycles -> wr_rdy_o=0 for all 4, pending data intact; first idle cycle drains, wr_rdy_o=1 the cycle after.
REQ-037 DEPTH=240: write adr 245 data 0xFF, then read adr 245 -> rd_dat_o=0; adr 239 read/write works normally.
REQ-038 rst pulsed mid-cycle with pnd_vld=1 -> outputs take reset values immediately, pend dropped, a read of that address returns the old array value.
REQ-039 Randomised read/write traffic against a reference array model -> every rd_dat_o matches the model, no write lost.
